// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op encodings, FSM state type and constants for the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Op encodings presented on the op port; 6 and 7 are no-ops.
    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

    // Quotient fill bit for divide-by-zero; replicated to the operand width.
    localparam logic DIV0_QUOT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/muldiv_abs.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_abs
// Description : Magnitude / conditional negate helper. Produces the sign of a
//               signed operand and returns value negated when the operand is
//               negative XOR a negate request is raised. Used for operand
//               magnitudes at accept and for result sign correction.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    input  logic             negate,
    output logic [WIDTH-1:0] result,
    output logic             sign
);

    assign sign   = is_signed & value[WIDTH-1];
    assign result = (sign ^ negate) ? ({WIDTH{1'b0}} - value) : value;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MIPS multiply/divide unit with HI/LO registers.
//               Shift-add multiply and restoring divide, one step per cycle,
//               on operand magnitudes with a sign fix-up in the last cycle.
//               Optional macro MULDIV_FAST_MUL_EN: multiplies use a single
//               combinational product and skip the iterative phase.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;

    // Latched operation context.
    logic                 is_div;
    logic                 neg_main;   // product / quotient negate
    logic                 neg_rem;    // remainder negate (sign of dividend)
    logic                 dz;         // divisor was zero
    logic [WIDTH-1:0]     opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     acc_hi;     // product high half / partial remainder
    logic [WIDTH-1:0]     acc_lo;     // multiplier / dividend -> quotient

    // Decode of the incoming request.
    logic                 idle;
    logic                 is_mul_op;
    logic                 arith_op;
    logic                 signed_op;
    logic                 accept;
    logic                 fast_accept;

    assign idle      = (state == ST_IDLE);
    assign is_mul_op = (op == OP_MULTU) || (op == OP_MULT);
    assign arith_op  = (op <= OP_DIV);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign accept    = start && idle && arith_op;

    // Operand magnitudes and signs, taken straight from the ports at accept.
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 sign_a;
    logic                 sign_b;

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value     (a),
        .is_signed (signed_op),
        .negate    (1'b0),
        .result    (mag_a),
        .sign      (sign_a)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value     (b),
        .is_signed (signed_op),
        .negate    (1'b0),
        .result    (mag_b),
        .sign      (sign_b)
    );

    // One shift-add multiply step: add multiplicand when the multiplier LSB
    // is set, then shift the double-width accumulator right by one.
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       add_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign addend   = acc_lo[0] ? opnd : {WIDTH{1'b0}};
    assign add_sum  = {1'b0, acc_hi} + {1'b0, addend};
    assign mul_next = {add_sum, acc_lo[WIDTH-1:1]};

    // One restoring divide step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits. A zero divisor
    // always fits, which yields an all-ones quotient and leaves the dividend
    // magnitude in the remainder.
    logic [WIDTH:0]       shifted;
    logic                 fits;
    logic [WIDTH-1:0]     diff;
    logic [2*WIDTH-1:0]   div_next;

    assign shifted  = {acc_hi, acc_lo[WIDTH-1]};
    assign fits     = (shifted >= {1'b0, opnd});
    assign diff     = shifted[WIDTH-1:0] - opnd;
    assign div_next = {(fits ? diff : shifted[WIDTH-1:0]), acc_lo[WIDTH-2:0], fits};

    // Raw product feeding the sign fix-up.
    logic [2*WIDTH-1:0]   prod_raw;

`ifdef MULDIV_FAST_MUL_EN
    assign fast_accept = is_mul_op;
    assign prod_raw    = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc_lo};
`else
    assign fast_accept = 1'b0;
    assign prod_raw    = {acc_hi, acc_lo};
`endif

    // Result sign correction.
    logic [2*WIDTH-1:0]   prod_res;
    logic [WIDTH-1:0]     quot_res;
    logic [WIDTH-1:0]     rem_res;
    logic                 unused_sign_p;
    logic                 unused_sign_q;
    logic                 unused_sign_r;

    muldiv_abs #(.WIDTH(2 * WIDTH)) u_fix_prod (
        .value     (prod_raw),
        .is_signed (1'b0),
        .negate    (neg_main),
        .result    (prod_res),
        .sign      (unused_sign_p)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_fix_quot (
        .value     (acc_lo),
        .is_signed (1'b0),
        .negate    (neg_main),
        .result    (quot_res),
        .sign      (unused_sign_q)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_fix_rem (
        .value     (acc_hi),
        .is_signed (1'b0),
        .negate    (neg_rem),
        .result    (rem_res),
        .sign      (unused_sign_r)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state and busy decode.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = fast_accept ? ST_FIXUP : ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    next_state = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                busy       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO writes and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div0     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        is_div   <= ~is_mul_op;
                        neg_main <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
                        dz       <= ~is_mul_op && (b == '0);
                        div0     <= 1'b0;
                        cnt      <= CNT_W'(WIDTH);
                        opnd     <= is_mul_op ? mag_a : mag_b;
                        acc_hi   <= '0;
                        acc_lo   <= is_mul_op ? mag_b : mag_a;
                    end else if (start && (op == OP_MTHI)) begin
                        hi <= a;
                    end else if (start && (op == OP_MTLO)) begin
                        lo <= a;
                    end
                end
                ST_CALC: begin
                    cnt              <= cnt - CNT_W'(1);
                    {acc_hi, acc_lo} <= is_div ? div_next : mul_next;
                end
                ST_FIXUP: begin
                    done <= 1'b1;
                    if (is_div) begin
                        hi   <= rem_res;
                        lo   <= dz ? {WIDTH{DIV0_QUOT}} : quot_res;
                        div0 <= dz;
                    end else begin
                        {hi, lo} <= prod_res;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers, for a multi-cycle or pipelined MIPS core.
- Supports MULTU, MULT, DIVU, DIV, MTHI and MTLO at a parametrised operand width.
- Uses one shift-add or restoring-division step per cycle.
- The core stalls any MFHI/MFLO or new muldiv op while busy is high.

Parameters:
- WIDTH, 32, operand width and HI/LO width (minimum 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on the posedge.
- reset  in  1  synchronous, active-high; sampled on the posedge of clk.
- start  in  1  request; accepted only on an edge where busy=0.
- op  in  3  0=MULTU 1=MULT 2=DIVU 3=DIV 4=MTHI 5=MTLO; 6 and 7 are no-ops.
- a  in  WIDTH  rs operand (dividend, multiplicand, or MTHI/MTLO data).
- b  in  WIDTH  rt operand (divisor or multiplier).
- busy  out  1  high while an arithmetic op is in flight.
- done  out  1  one-cycle pulse when HI/LO take a mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div0  out  1  sticky flag: last divide had b==0; cleared on next accepted mul/div.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, div0=0, counter=0. Reset takes effect mid-operation and discards any in-flight op.
- FSM states: IDLE, CALC, FIXUP.
  - IDLE: start & op in 0..3 → latch operands and sign info, counter=WIDTH, busy=1 → CALC.
  - IDLE: start & op=4/5 → write hi/lo=a at that edge; busy stays 0; no done.
  - IDLE: op 6/7 ignored.
  - CALC: one step per edge, counter decrements; counter reaches 1 → FIXUP next.
  - FIXUP: apply sign correction, write hi/lo, done=1 for the next cycle, busy=0 → IDLE.
- Latency: start accepted at edge E0; hi/lo written at edge E0+WIDTH+1; busy high for exactly WIDTH+1 cycles.
- hi/lo hold their old values until the FIXUP edge.
- start while busy is ignored: no queueing, no error.
- A new start is accepted in the cycle done=1, since busy is already 0 then.
- Multiply: shift-add on magnitudes, 2*WIDTH-bit accumulator; hi=upper WIDTH bits, lo=lower WIDTH bits.
  - MULT: product negated if sign(a)^sign(b).
- Divide: restoring division on magnitudes; lo=quotient, hi=remainder.
  - DIV: quotient negated if sign(a)^sign(b); remainder takes the sign of a.
  - DIV of MIN by -1: lo=MIN, hi=0; no trap.
- Divide by zero (b==0): runs the full latency; lo=all ones, hi=a (unsigned magnitude restored with sign for DIV); div0=1.
- Operands are registered at accept; a and b may change afterwards.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULTU/MULT use a combinational WIDTH×WIDTH product and skip CALC. The edge after accept is FIXUP, so hi/lo are written at E0+1, busy is high 1 cycle, done pulses the following cycle. Divide is unchanged.
- Undefined: all ops use the iterative path with WIDTH+1 latency.

Decomposition:
- Package muldiv_pkg: op encodings (OP_MULTU…OP_MTLO), FSM state enum, DIV0_QUOT constant (all ones).
- One natural sub-module, muldiv_abs: converts a signed/unsigned operand to its magnitude plus a sign flag, and applies the conditional two's-complement negate in FIXUP. It is instantiated for both operands and for the result.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy high exactly 33 cycles.
- MULT a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100, div0=1. Next MULTU 2×3 → div0=0, lo=6, hi=0.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Start pulse at cycle 5 of busy is ignored and results are unaffected.
- MTHI a=0x1234 then MTLO a=0x5678 on consecutive cycles → hi=0x1234, lo=0x5678 with busy never asserted. Reset asserted at cycle 10 of a DIVU → next cycle busy=0, hi=lo=0, no done.
- With MULDIV_FAST_MUL_EN: MULTU 0x10000×0x10000 → hi=1, lo=0 at E0+1, busy high 1 cycle. WIDTH=8 build: DIVU 200/7 → lo=28, hi=4 after 9 cycles.
